// File: rtl/pipe_pkg.sv
// Shared definitions for the instruction pipeline: bubble word, opcode classes,
// stage indices and the per-stage register mode.
package pipe_pkg;

    localparam logic [31:0] NOP_WORD = 32'hFC00_0000;

    localparam logic [5:0] OP_STORE = 6'd13;
    localparam logic [5:0] OP_LOAD  = 6'd14;
    localparam logic [5:0] OP_BEQ   = 6'd15;
    localparam logic [5:0] OP_BNE   = 6'd16;

    // Opcode class bounds used by the hazard/forwarding decoder
    localparam logic [5:0] CLS_A_LIMIT = 6'd3;
    localparam logic [5:0] CLS_BC_LO   = 6'd5;
    localparam logic [5:0] CLS_BC_HI   = 6'd13;
    localparam logic [5:0] CLS_D       = 6'd14;
    localparam logic [5:0] CLS_E_LO    = 6'd15;
    localparam logic [5:0] CLS_E_HI    = 6'd16;

    typedef enum logic [1:0] {
        ST_II = 2'd0,
        ST_IE = 2'd1,
        ST_EM = 2'd2,
        ST_MW = 2'd3
    } stage_e;

    typedef enum logic [1:0] {
        MODE_LOAD   = 2'd0,
        MODE_HOLD   = 2'd1,
        MODE_BUBBLE = 2'd2
    } stage_mode_e;

    function automatic logic [5:0] opcodeOf(input logic [31:0] word);
        return word[31:26];
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage register (word, pc, valid) with load / hold / bubble modes.
// Latency 1 cycle; bubbling keeps the PC so bubble stages stay deterministic.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int              IW       = 32,
    parameter int              PW       = 32,
    parameter logic [IW-1:0]   NOP_WORD = IW'(pipe_pkg::NOP_WORD)
) (
    input  logic          clk,
    input  logic          rst,
    input  stage_mode_e   mode,
    input  logic [IW-1:0] wordIn,
    input  logic [PW-1:0] pcIn,
    input  logic          validIn,
    output logic [IW-1:0] wordQ,
    output logic [PW-1:0] pcQ,
    output logic          validQ
);

    always_ff @(posedge clk) begin
        if (rst) begin
            wordQ  <= NOP_WORD;
            pcQ    <= '0;
            validQ <= 1'b0;
        end else begin
            unique case (mode)
                MODE_LOAD: begin
                    wordQ  <= wordIn;
                    pcQ    <= pcIn;
                    validQ <= validIn;
                end
                MODE_BUBBLE: begin
                    wordQ  <= NOP_WORD;
                    validQ <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_instr_regs.sv
// IF/ID, ID/EX, EX/MEM, MEM/WB register file driven by stall/flush decisions.
// Latency 1 cycle per stage; stall holds II/IE and asks fetch to repeat via pc_hold.
module pipe_instr_regs
    import pipe_pkg::*;
#(
    parameter int            IW       = 32,
    parameter int            PW       = 32,
    parameter int            CW       = 32,
    parameter logic [IW-1:0] NOP_WORD = IW'(pipe_pkg::NOP_WORD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] instr_in,
    input  logic [PW-1:0] pc_in,
    input  logic          stall,
    input  logic          flush_br,
    input  logic          flush_j,
    output logic [IW-1:0] iiO,
    output logic [IW-1:0] ieO,
    output logic [IW-1:0] emO,
    output logic [IW-1:0] mwO,
    output logic [PW-1:0] ii_pc,
    output logic [PW-1:0] ie_pc,
    output logic [PW-1:0] em_pc,
    output logic [PW-1:0] mw_pc,
    output logic [3:0]    valid,
    output logic          pc_hold,
    output logic [CW-1:0] retired_cnt
);

    logic [IW-1:0] stWord  [4];
    logic [PW-1:0] stPc    [4];
    logic          stValid [4];
    stage_mode_e   stMode  [4];

    // Priority: flush_br > stall > flush_j > advance; MEM/WB always loads
    always_comb begin
        stMode[int'(ST_II)] = MODE_LOAD;
        stMode[int'(ST_IE)] = MODE_LOAD;
        stMode[int'(ST_EM)] = MODE_LOAD;
        stMode[int'(ST_MW)] = MODE_LOAD;
        if (flush_br) begin
            stMode[int'(ST_II)] = MODE_BUBBLE;
            stMode[int'(ST_IE)] = MODE_BUBBLE;
            stMode[int'(ST_EM)] = MODE_BUBBLE;
        end else if (stall) begin
            stMode[int'(ST_II)] = MODE_HOLD;
            stMode[int'(ST_IE)] = MODE_HOLD;
            stMode[int'(ST_EM)] = MODE_BUBBLE;
        end else if (flush_j) begin
            stMode[int'(ST_II)] = MODE_BUBBLE;
        end
    end

    for (genvar s = 0; s < 4; s++) begin : g_stage
        if (s == 0) begin : g_first
            pipe_stage_reg #(.IW(IW), .PW(PW), .NOP_WORD(NOP_WORD)) u_stage (
                .clk(clk), .rst(rst), .mode(stMode[s]),
                .wordIn(instr_in), .pcIn(pc_in), .validIn(1'b1),
                .wordQ(stWord[s]), .pcQ(stPc[s]), .validQ(stValid[s])
            );
        end else begin : g_next
            pipe_stage_reg #(.IW(IW), .PW(PW), .NOP_WORD(NOP_WORD)) u_stage (
                .clk(clk), .rst(rst), .mode(stMode[s]),
                .wordIn(stWord[s-1]), .pcIn(stPc[s-1]), .validIn(stValid[s-1]),
                .wordQ(stWord[s]), .pcQ(stPc[s]), .validQ(stValid[s])
            );
        end
    end

    assign iiO   = stWord[int'(ST_II)];
    assign ieO   = stWord[int'(ST_IE)];
    assign emO   = stWord[int'(ST_EM)];
    assign mwO   = stWord[int'(ST_MW)];
    assign ii_pc = stPc[int'(ST_II)];
    assign ie_pc = stPc[int'(ST_IE)];
    assign em_pc = stPc[int'(ST_EM)];
    assign mw_pc = stPc[int'(ST_MW)];
    assign valid = {stValid[3], stValid[2], stValid[1], stValid[0]};

    // A taken branch redirects fetch, so it cancels the load-use hold
    assign pc_hold = stall & ~flush_br;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt <= '0;
        end else if (stValid[int'(ST_MW)]) begin
            retired_cnt <= retired_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_instr_regs.sv
// Scoreboarded bench: each driven cycle pushes the expected pipeline snapshot,
// which is popped and compared one edge later, plus directed scenario checks.
module tb_pipe_instr_regs;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst, stall, flush_br, flush_j;
    logic [31:0] instr_in, pc_in;
    logic [31:0] iiO, ieO, emO, mwO, ii_pc, ie_pc, em_pc, mw_pc;
    logic [3:0]  valid;
    logic        pc_hold;
    logic [3:0]  retired_cnt;

    always #5 clk = ~clk;

    pipe_instr_regs #(.IW(32), .PW(32), .CW(4)) dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
        .stall(stall), .flush_br(flush_br), .flush_j(flush_j),
        .iiO(iiO), .ieO(ieO), .emO(emO), .mwO(mwO),
        .ii_pc(ii_pc), .ie_pc(ie_pc), .em_pc(em_pc), .mw_pc(mw_pc),
        .valid(valid), .pc_hold(pc_hold), .retired_cnt(retired_cnt)
    );

    typedef struct packed {
        logic [3:0][31:0] w;
        logic [3:0][31:0] p;
        logic [3:0]       v;
        logic [3:0]       cnt;
    } snap_t;

    snap_t model = '0;
    snap_t expQ[$];
    int    checks = 0;
    int    errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic [31:0] pcv,
                        input logic st, input logic fb, input logic fj, input logic r);
        snap_t nx, ex;
        rst = r; instr_in = ins; pc_in = pcv; stall = st; flush_br = fb; flush_j = fj;
        #1;
        checkVal("pc_hold", {31'b0, pc_hold}, {31'b0, st & ~fb});
        nx = model;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                nx.w[i] = NOP;
                nx.p[i] = '0;
            end
            nx.v = '0;
            nx.cnt = '0;
        end else begin
            nx.cnt = model.cnt + {3'b0, model.v[3]};
            nx.w[3] = model.w[2]; nx.p[3] = model.p[2]; nx.v[3] = model.v[2];
            if (fb) begin
                for (int i = 0; i < 3; i++) begin
                    nx.w[i] = NOP;
                    nx.v[i] = 1'b0;
                end
            end else if (st) begin
                nx.w[2] = NOP; nx.v[2] = 1'b0;
            end else begin
                nx.w[2] = model.w[1]; nx.p[2] = model.p[1]; nx.v[2] = model.v[1];
                nx.w[1] = model.w[0]; nx.p[1] = model.p[0]; nx.v[1] = model.v[0];
                if (fj) begin
                    nx.w[0] = NOP; nx.v[0] = 1'b0;
                end else begin
                    nx.w[0] = ins; nx.p[0] = pcv; nx.v[0] = 1'b1;
                end
            end
        end
        model = nx;
        expQ.push_back(nx);
        @(posedge clk);
        #1;
        ex = expQ.pop_front();
        checkVal("iiO", iiO, ex.w[0]);
        checkVal("ieO", ieO, ex.w[1]);
        checkVal("emO", emO, ex.w[2]);
        checkVal("mwO", mwO, ex.w[3]);
        checkVal("ii_pc", ii_pc, ex.p[0]);
        checkVal("ie_pc", ie_pc, ex.p[1]);
        checkVal("em_pc", em_pc, ex.p[2]);
        checkVal("mw_pc", mw_pc, ex.p[3]);
        checkVal("valid", {28'b0, valid}, {28'b0, ex.v});
        checkVal("retired_cnt", {28'b0, retired_cnt}, {28'b0, ex.cnt});
    endtask

    task automatic feed(input logic [31:0] ins, input logic [31:0] pcv);
        step(ins, pcv, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("reset_valid", {28'b0, valid}, 32'h0);
        checkVal("reset_mwO", mwO, NOP);

        // straight-line flow
        for (int k = 0; k < 6; k++) begin
            feed(32'h0400_0001 + k, 32'(4 * k));
            if (k == 3) checkVal("latency4_mwO", mwO, 32'h0400_0001);
        end
        drain(4);
        checkVal("retired6", {28'b0, retired_cnt}, 32'd6);

        // reset mid-stream
        feed(32'h0400_00A1, 32'h40);
        feed(32'h0400_00A2, 32'h44);
        feed(32'h0400_00A3, 32'h48);
        step(32'h0400_00A4, 32'h4C, 1'b0, 1'b0, 1'b0, 1'b1);
        checkVal("midrst_iiO", iiO, NOP);
        checkVal("midrst_emO", emO, NOP);
        checkVal("midrst_valid", {28'b0, valid}, 32'h0);
        checkVal("midrst_cnt", {28'b0, retired_cnt}, 32'h0);

        // load-use stall
        feed(32'h3800_0000, 32'h100);
        feed(32'h0400_0011, 32'h104);
        feed(32'h0400_0012, 32'h108);
        step(32'h0400_0013, 32'h10C, 1'b1, 1'b0, 1'b0, 1'b0);
        checkVal("stall_iiO", iiO, 32'h0400_0012);
        checkVal("stall_ieO", ieO, 32'h0400_0011);
        checkVal("stall_emO", emO, NOP);
        checkVal("stall_em_valid", {31'b0, valid[2]}, 32'h0);
        checkVal("stall_mwO", mwO, 32'h3800_0000);

        // taken branch with simultaneous stall
        feed(32'h3C00_0000, 32'h200);
        feed(32'h0400_0021, 32'h204);
        feed(32'h0400_0022, 32'h208);
        step(32'h0400_0023, 32'h20C, 1'b1, 1'b1, 1'b0, 1'b0);
        checkVal("br_mwO", mwO, 32'h3C00_0000);
        checkVal("br_iiO", iiO, NOP);
        checkVal("br_ieO", ieO, NOP);
        checkVal("br_emO", emO, NOP);
        checkVal("br_valid", {29'b0, valid[2:0]}, 32'h0);

        // jump, then jump held by a stall
        feed(32'h0400_0031, 32'h300);
        feed(32'h0800_0040, 32'h304);
        step(32'h0400_0099, 32'h308, 1'b0, 1'b0, 1'b1, 1'b0);
        checkVal("jmp_ieO", ieO, 32'h0800_0040);
        checkVal("jmp_iiO", iiO, NOP);
        feed(32'h0800_0050, 32'h400);
        step(32'h0400_0098, 32'h404, 1'b1, 1'b0, 1'b1, 1'b0);
        checkVal("jmpstall_iiO", iiO, 32'h0800_0050);
        checkVal("jmpstall_ii_valid", {31'b0, valid[0]}, 32'h1);

        // counter wrap with a 4-bit counter
        step(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 17; k++) feed(32'h0400_1000 + k, 32'(4 * k));
        drain(4);
        checkVal("wrap_cnt", {28'b0, retired_cnt}, 32'd1);

        // randomized hazards
        for (int k = 0; k < 300; k++) begin
            step($urandom, $urandom,
                 ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 40) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
